// File: rtl/spi_sram_responder.sv
// spi_sram_responder: SPI mode-0 target emulating a 16-bit-word serial SRAM with a backdoor port
// Ports: clk, spi_rst (async active-high reset), spi_cs_n/spi_sclk/spi_mosi (SPI in),
//   spi_miso/spi_miso_oe (SPI out), busy (CS asserted), bd_we/bd_addr/bd_wdata/bd_rdata (backdoor).
// Option: define SPI_SRAM_STATUS_EN for the status register (RDSR 0x05, WRSR 0x01, bit0 write-protect).
module spi_sram_responder #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          spi_rst,
    input  logic          spi_cs_n,
    input  logic          spi_sclk,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          spi_miso_oe,
    output logic          busy,
    input  logic          bd_we,
    input  logic [AW-1:0] bd_addr,
    input  logic [15:0]   bd_wdata,
    output logic [15:0]   bd_rdata
);
    typedef enum logic [3:0] {IDLE, CMD, ADDR_HI, ADDR_LO, WDATA, RDATA, IGNORE, STAT_RD, STAT_WR} state_t;
    state_t        state_q, state_d;
    logic [1:0]    cs_q, sclk_q, mosi_q;
    logic          sclk_prev_q, busy_q;
    logic [3:0]    cnt_q, cnt_d;
    logic [14:0]   sin_q, sin_d;
    logic [15:0]   sout_q, sout_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wr_q, wr_d;
    // lead: the first falling edge after entering a read phase only presents bit 15
    logic          lead_q, lead_d;
    logic [15:0]   bd_rdata_q;
    logic [15:0]   mem [DEPTH];
    logic          cs_s, sclk_s, mosi_s, rise, fall, wp, mem_we;
    logic [15:0]   word;
    logic [AW-1:0] new_addr, addr_inc;
`ifdef SPI_SRAM_STATUS_EN
    logic [7:0]    stat_q, stat_d;
    assign wp = stat_q[0];
`else
    assign wp = 1'b0;
`endif
    assign cs_s        = cs_q[1];
    assign sclk_s      = sclk_q[1];
    assign mosi_s      = mosi_q[1];
    assign rise        = sclk_s & ~sclk_prev_q;
    assign fall        = ~sclk_s & sclk_prev_q;
    assign word        = {sin_q, mosi_s};
    assign new_addr    = AW'(32'(word) % DEPTH);
    assign addr_inc    = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
    assign spi_miso_oe = (state_q == RDATA) || (state_q == STAT_RD);
    assign spi_miso    = spi_miso_oe & sout_q[15];
    assign busy        = busy_q;
    assign bd_rdata    = bd_rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sin_d   = sin_q;
        sout_d  = sout_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        lead_d  = lead_q;
        mem_we  = 1'b0;
`ifdef SPI_SRAM_STATUS_EN
        stat_d  = stat_q;
`endif
        if (cs_s) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = CMD;
                CMD: if (rise) begin
                    sin_d = word[14:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = '0;
                        case (word[7:0])
                            8'h02: begin state_d = ADDR_HI; wr_d = 1'b1; end
                            8'h03: begin state_d = ADDR_HI; wr_d = 1'b0; end
`ifdef SPI_SRAM_STATUS_EN
                            8'h05: begin state_d = STAT_RD; sout_d = {stat_q, 8'h00}; lead_d = 1'b1; end
                            8'h01: state_d = STAT_WR;
`endif
                            default: state_d = IGNORE;
                        endcase
                    end
                end
                ADDR_HI: if (rise) begin
                    sin_d = word[14:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = '0;
                        state_d = ADDR_LO;
                    end
                end
                ADDR_LO: if (rise) begin
                    sin_d = word[14:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = '0;
                        addr_d  = new_addr;
                        state_d = wr_q ? WDATA : RDATA;
                        sout_d  = mem[new_addr];
                        lead_d  = 1'b1;
                    end
                end
                WDATA: if (rise) begin
                    sin_d = word[14:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == 4'd15) begin
                        cnt_d  = '0;
                        mem_we = ~wp;
                        addr_d = addr_inc;
                    end
                end
                RDATA: if (fall) begin
                    lead_d = 1'b0;
                    if (!lead_q) begin
                        sout_d = sout_q << 1;
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == 4'd15) begin
                            cnt_d  = '0;
                            addr_d = addr_inc;
                            sout_d = mem[addr_inc];
                        end
                    end
                end
`ifdef SPI_SRAM_STATUS_EN
                STAT_RD: if (fall) begin
                    lead_d = 1'b0;
                    if (!lead_q) begin
                        sout_d = sout_q << 1;
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == 4'd7) begin
                            cnt_d  = '0;
                            sout_d = {stat_q, 8'h00};
                        end
                    end
                end
                STAT_WR: if (rise) begin
                    sin_d = word[14:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == 4'd7) begin
                        stat_d  = word[7:0];
                        state_d = IGNORE;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge spi_rst) begin
        if (spi_rst) begin
            cs_q        <= 2'b11;
            sclk_q      <= '0;
            mosi_q      <= '0;
            sclk_prev_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            sin_q       <= '0;
            sout_q      <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            lead_q      <= 1'b0;
            bd_rdata_q  <= '0;
        end else begin
            cs_q        <= {cs_q[0], spi_cs_n};
            sclk_q      <= {sclk_q[0], spi_sclk};
            mosi_q      <= {mosi_q[0], spi_mosi};
            sclk_prev_q <= sclk_s;
            busy_q      <= ~cs_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sin_q       <= sin_d;
            sout_q      <= sout_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            lead_q      <= lead_d;
            bd_rdata_q  <= mem[bd_addr];
        end
    end

`ifdef SPI_SRAM_STATUS_EN
    always_ff @(posedge clk or posedge spi_rst) begin
        if (spi_rst) stat_q <= '0;
        else         stat_q <= stat_d;
    end
`endif

    // SPI writes only happen while busy, so the backdoor never collides with them
    always_ff @(posedge clk) begin
        if (mem_we)                mem[addr_q]  <= word;
        else if (bd_we && !busy_q) mem[bd_addr] <= bd_wdata;
    end
endmodule

// File: tb/tb_spi_sram_responder.sv
// tb_spi_sram_responder: self-checking bench for spi_sram_responder against a word-array model
module tb_spi_sram_responder;
    logic        clk = 1'b0;
    logic        spi_rst, spi_cs_n, spi_sclk, spi_mosi, spi_miso, spi_miso_oe, busy, bd_we;
    logic [9:0]  bd_addr;
    logic [15:0] bd_wdata, bd_rdata;
    int          n_vec = 0, n_bad = 0;
    logic [15:0] model [1024];
    logic [15:0] wq[$], rq[$];
    logic        oe_and, oe_or, wp_m = 1'b0;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    spi_sram_responder dut (
        .clk(clk), .spi_rst(spi_rst), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .busy(busy),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one mode-0 bit per loop: set MOSI, hold low, sample MISO, rise, hold high, fall
    task automatic bits(input logic [31:0] dout, input int n, output logic [31:0] din);
        din = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = dout[i];
            wait_clk(4);
            din[i] = spi_miso;
            oe_and &= spi_miso_oe;
            oe_or  |= spi_miso_oe;
            spi_sclk = 1'b1;
            wait_clk(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic cs_end();
        wait_clk(4);
        spi_cs_n = 1'b1;
        wait_clk(5);
    endtask

    task automatic spi_write(input logic [15:0] a, input int partial);
        logic [31:0] d;
        cs_begin();
        bits(32'h02, 8, d);
        bits({16'h0, a}, 16, d);
        foreach (wq[k]) bits({16'h0, wq[k]}, 16, d);
        if (partial > 0) bits(32'($urandom), partial, d);
        cs_end();
        if (!wp_m) foreach (wq[k]) model[(int'(a) + k) % 1024] = wq[k];
    endtask

    task automatic spi_read(input logic [15:0] a, input int n);
        logic [31:0] d;
        rq.delete();
        cs_begin();
        bits(32'h03, 8, d);
        bits({16'h0, a}, 16, d);
        oe_and = 1'b1;
        for (int k = 0; k < n; k++) begin
            bits(32'h0, 16, d);
            rq.push_back(d[15:0]);
        end
        cs_end();
    endtask

    task automatic cmd_byte2(input logic [7:0] c, input logic [7:0] v);
        logic [31:0] d;
        cs_begin();
        bits({24'h0, c}, 8, d);
        bits({24'h0, v}, 8, d);
        cs_end();
    endtask

    task automatic bd_write(input logic [9:0] a, input logic [15:0] v);
        bd_addr  = a;
        bd_wdata = v;
        bd_we    = 1'b1;
        wait_clk(1);
        bd_we    = 1'b0;
    endtask

    task automatic bd_read(input logic [9:0] a, output logic [15:0] v);
        bd_addr = a;
        wait_clk(2);
        v = bd_rdata;
    endtask

    initial begin
        vec_t        tbl[10];
        logic [31:0] d;
        logic [15:0] v;
        logic [15:0] a;
        int          n, op;
        spi_rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
        wait_clk(3);
        check("rst_miso", {31'h0, spi_miso}, 32'h0);
        check("rst_oe", {31'h0, spi_miso_oe}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_bd_rdata", {16'h0, bd_rdata}, 32'h0);
        spi_rst = 1'b0;
        wait_clk(2);
        for (int i = 0; i < 1024; i++) begin
            model[i] = 16'($urandom);
            bd_write(10'(i), model[i]);
        end

        tbl = '{
            '{1'b1, 16'h0010, 16'hBEEF, 16'hBEEF},
            '{1'b0, 16'h0010, 16'h0000, 16'hBEEF},
            '{1'b1, 16'h0410, 16'h1234, 16'h1234},
            '{1'b0, 16'h0010, 16'h0000, 16'h1234},
            '{1'b1, 16'h03FE, 16'h8001, 16'h8001},
            '{1'b0, 16'hFBFE, 16'h0000, 16'h8001},
            '{1'b1, 16'h0400, 16'h0000, 16'h0000},
            '{1'b0, 16'h0000, 16'h0000, 16'h0000},
            '{1'b1, 16'h0155, 16'hFFFF, 16'hFFFF},
            '{1'b0, 16'hC155, 16'h0000, 16'hFFFF}
        };
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].wr) begin
                wq = '{tbl[i].data};
                spi_write(tbl[i].addr, 0);
                bd_read(tbl[i].addr[9:0], v);
                check($sformatf("tbl%0d_bd", i), {16'h0, v}, {16'h0, tbl[i].exp});
            end else begin
                spi_read(tbl[i].addr, 1);
                check($sformatf("tbl%0d_miso", i), {16'h0, rq[0]}, {16'h0, tbl[i].exp});
                check($sformatf("tbl%0d_oe", i), {31'h0, oe_and}, 32'h1);
            end
        end

        // sequential write across the top of memory
        wq = '{16'h1111, 16'h2222};
        spi_write(16'h03FF, 0);
        bd_read(10'h3FF, v);
        check("seq_bd_3ff", {16'h0, v}, 32'h1111);
        bd_read(10'h000, v);
        check("seq_bd_000", {16'h0, v}, 32'h2222);
        spi_read(16'h03FF, 3);
        check("seq_rd0", {16'h0, rq[0]}, 32'h1111);
        check("seq_rd1", {16'h0, rq[1]}, 32'h2222);
        check("seq_rd2", {16'h0, rq[2]}, {16'h0, model[1]});

        // 9 data bits then CS high: no write; busy drops on the third clock
        cs_begin();
        bits(32'h02, 8, d);
        bits(32'h0020, 16, d);
        bits(32'h1FF, 9, d);
        wait_clk(4);
        spi_cs_n = 1'b1;
        wait_clk(2);
        check("busy_hold_2clk", {31'h0, busy}, 32'h1);
        wait_clk(1);
        check("busy_fall_3clk", {31'h0, busy}, 32'h0);
        wait_clk(3);
        bd_read(10'h020, v);
        check("partial_nowrite", {16'h0, v}, {16'h0, model[32'h20]});

        // unknown command then 32 clocks
        oe_or = 1'b0;
        cs_begin();
        bits(32'h9F, 8, d);
        for (int k = 0; k < 32; k++) bits(32'($urandom), 1, d);
        cs_end();
        check("ignore_oe", {31'h0, oe_or}, 32'h0);
        bd_read(10'h000, v);
        check("ignore_mem", {16'h0, v}, {16'h0, model[0]});
        spi_read(16'h0010, 1);
        check("after_ignore_rd", {16'h0, rq[0]}, {16'h0, model[16]});

        // backdoor write while busy is dropped
        cs_begin();
        bd_write(10'h030, ~model[48]);
        cs_end();
        bd_read(10'h030, v);
        check("bd_while_busy", {16'h0, v}, {16'h0, model[48]});

        // reset in the middle of a read
        cs_begin();
        bits(32'h03, 8, d);
        bits(32'h0010, 16, d);
        bits(32'h0, 5, d);
        spi_rst = 1'b1;
        wait_clk(1);
        check("midrst_miso", {31'h0, spi_miso}, 32'h0);
        check("midrst_oe", {31'h0, spi_miso_oe}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_bd", {16'h0, bd_rdata}, 32'h0);
        spi_rst = 1'b0;
        spi_cs_n = 1'b1;
        wait_clk(5);
        spi_read(16'h0010, 1);
        check("midrst_reread", {16'h0, rq[0]}, {16'h0, model[16]});

        // randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 3));
            a  = 16'($urandom);
            n  = int'($urandom_range(1, 3));
            if (op == 0) begin
                wq.delete();
                for (int k = 0; k < n; k++) wq.push_back(16'($urandom));
                spi_write(a, int'($urandom_range(0, 15)));
            end else if (op == 1) begin
                spi_read(a, n);
                for (int k = 0; k < n; k++)
                    check("rand_read", {16'h0, rq[k]}, {16'h0, model[(int'(a) + k) % 1024]});
            end else if (op == 2) begin
                v = 16'($urandom);
                bd_write(a[9:0], v);
                model[a[9:0]] = v;
            end else begin
                bd_read(a[9:0], v);
                check("rand_bd", {16'h0, v}, {16'h0, model[a[9:0]]});
            end
        end

        // status register
        cmd_byte2(8'h01, 8'h01);
`ifdef SPI_SRAM_STATUS_EN
        wp_m = 1'b1;
`endif
        wq = '{16'hAAAA};
        spi_write(16'h0005, 0);
        bd_read(10'h005, v);
        check("wp_write", {16'h0, v}, {16'h0, model[5]});
        oe_or = 1'b0;
        cs_begin();
        bits(32'h05, 8, d);
        bits(32'h0, 16, d);
        cs_end();
`ifdef SPI_SRAM_STATUS_EN
        check("rdsr", d, 32'h0101);
        cmd_byte2(8'h01, 8'h00);
        wp_m = 1'b0;
        wq = '{16'h5555};
        spi_write(16'h0005, 0);
        bd_read(10'h005, v);
        check("unprotected_write", {16'h0, v}, 32'h5555);
`else
        check("rdsr_ignored_oe", {31'h0, oe_or}, 32'h0);
        check("nostat_write", {16'h0, v}, 32'hAAAA);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
